// File: rtl/ysyx_040066_memrd_arb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_040066_mem_pkg
// Shared types and widths for the memory read-port arbiter.
//   state_e : arbiter sequencing state (IDLE / BUSY / HOLD)
//   owner_e : which requester owns the outstanding transaction
//   ADDR_W / DATA_W / INSTR_W : bus widths
// ---------------------------------------------------------------------------
package ysyx_040066_mem_pkg;

   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned INSTR_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // free, arbitrating
      BUSY = 2'd1,   // request accepted, waiting for mem_rvalid
      HOLD = 2'd2    // response registered, waiting for owner's rready
   } state_e;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } owner_e;

endpackage

// File: rtl/ysyx_040066_memrd_arb_if.sv
// ---------------------------------------------------------------------------
// ysyx_040066_memrd_arb_if
// Bundles the fetch requester, load requester and memory port signals.
//   slave  : arbiter view (takes requests, drives the memory port)
//   master : environment view (requesters + memory)
// ---------------------------------------------------------------------------
interface ysyx_040066_memrd_arb_if;
   import ysyx_040066_mem_pkg::*;

   // fetch requester
   logic               i_req;
   logic [ADDR_W-1:0]  i_addr;
   logic               i_ready;
   logic               i_rvalid;
   logic               i_rready;
   logic [INSTR_W-1:0] i_instr;
   logic               i_rerr;
   logic               i_flush;
   // load requester
   logic               d_req;
   logic [ADDR_W-1:0]  d_addr;
   logic               d_ready;
   logic               d_rvalid;
   logic               d_rready;
   logic [DATA_W-1:0]  d_rdata;
   logic               d_rerr;
   // memory port
   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_gnt;
   logic               mem_rvalid;
   logic [DATA_W-1:0]  mem_rdata;
   logic               mem_rerr;

   modport slave (
      input  i_req, i_addr, i_rready, i_flush,
      input  d_req, d_addr, d_rready,
      input  mem_gnt, mem_rvalid, mem_rdata, mem_rerr,
      output i_ready, i_rvalid, i_instr, i_rerr,
      output d_ready, d_rvalid, d_rdata, d_rerr,
      output mem_req, mem_addr
   );

   modport master (
      output i_req, i_addr, i_rready, i_flush,
      output d_req, d_addr, d_rready,
      output mem_gnt, mem_rvalid, mem_rdata, mem_rerr,
      input  i_ready, i_rvalid, i_instr, i_rerr,
      input  d_ready, d_rvalid, d_rdata, d_rerr,
      input  mem_req, mem_addr
   );

endinterface

// File: rtl/ysyx_040066_memrd_arb_rsp_buf.sv
// ---------------------------------------------------------------------------
// ysyx_040066_rsp_buf
// One-entry response register between the memory port and the requesters.
//   clk, rst       : clock, asynchronous active-low reset
//   load           : capture load_data/load_err and mark the entry valid
//   drop           : release the entry (consumed or flushed)
//   valid/data/err : registered entry
// The data and error registers keep their value after a drop; only the
// valid flag is cleared.
// ---------------------------------------------------------------------------
module ysyx_040066_rsp_buf
   import ysyx_040066_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_err,
   input  logic              drop,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              err
);

   // NOTE: state is written with non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would create order-dependent logic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         // NOTE: the data register is reset on purpose: the data outputs are
         // required to read zero straight out of reset.
         data  <= '0;
         err   <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         err   <= load_err;
      end else if (drop) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ysyx_040066_memrd_arb.sv
// ---------------------------------------------------------------------------
// ysyx_040066_memrd_arb
// Shares the single memory read port between instruction fetch and data load.
// One outstanding transaction; the response is held until its owner accepts
// it. Fetch responses can be discarded by i_flush.
//   MAX_DSTREAK : consecutive data grants allowed while fetch waits
//   clk, rst    : clock, asynchronous active-low reset
//   bus         : fetch / load / memory handshakes (slave modport)
// ---------------------------------------------------------------------------
module ysyx_040066_memrd_arb
   import ysyx_040066_mem_pkg::*;
#(
   parameter int unsigned MAX_DSTREAK = 4
) (
   input logic                    clk,
   input logic                    rst,
   ysyx_040066_memrd_arb_if.slave bus
);

   localparam int unsigned          STREAK_W   = $clog2(MAX_DSTREAK + 1);
   localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_DSTREAK);

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic                pc2_q, pc2_d;
   logic                flush_pend_q, flush_pend_d;
   logic [STREAK_W-1:0] dstreak_q, dstreak_d;

   logic                fetch_force, data_wins, mem_req, accept, own_fetch;
   logic                buf_load, buf_drop, buf_valid, buf_err;
   logic [DATA_W-1:0]   buf_data;
   logic                i_rvalid, d_rvalid;

   // ---------------- arbitration (only effective in IDLE) ----------------
   // Data wins unless fetch has been starved for MAX_DSTREAK data grants.
   assign own_fetch   = (owner_q == FETCH);
   assign fetch_force = bus.i_req && (dstreak_q == STREAK_MAX);
   assign data_wins   = bus.d_req && !fetch_force;
   assign mem_req     = (state_q == IDLE) && (bus.i_req || bus.d_req);
   assign accept      = mem_req && bus.mem_gnt;

   assign bus.mem_req  = mem_req;
   assign bus.mem_addr = data_wins ? bus.d_addr : bus.i_addr;
   assign bus.d_ready  = accept && data_wins;
   assign bus.i_ready  = accept && !data_wins;

   // ---------------- FSM, owner, streak, flush-pending ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         owner_q      <= DATA;
         pc2_q        <= 1'b0;
         flush_pend_q <= 1'b0;
         dstreak_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         pc2_q        <= pc2_d;
         flush_pend_q <= flush_pend_d;
         dstreak_q    <= dstreak_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_d      = state_q;
      owner_d      = owner_q;
      pc2_d        = pc2_q;
      flush_pend_d = flush_pend_q;
      dstreak_d    = dstreak_q;
      buf_load     = 1'b0;
      buf_drop     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = BUSY;
               if (data_wins) begin
                  owner_d = DATA;
                  // streak only counts data grants that made fetch wait
                  if (!bus.i_req)
                     dstreak_d = '0;
                  else if (dstreak_q != STREAK_MAX)
                     dstreak_d = dstreak_q + 1'b1;
               end else begin
                  owner_d   = FETCH;
                  pc2_d     = bus.i_addr[2];
                  dstreak_d = '0;
               end
            end
         end
         BUSY: begin
            if (bus.mem_rvalid) begin
               // a flush in the same cycle as the response also discards it
               if (own_fetch && (flush_pend_q || bus.i_flush)) begin
                  state_d = IDLE;
               end else begin
                  buf_load = 1'b1;
                  state_d  = HOLD;
               end
            end else if (own_fetch && bus.i_flush) begin
               flush_pend_d = 1'b1;
            end
         end
         HOLD: begin
            // flush and rready together: treated as a flush, same exit
            if (own_fetch ? (bus.i_flush || bus.i_rready) : bus.d_rready) begin
               buf_drop = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d == IDLE) flush_pend_d = 1'b0;
   end

   // ---------------- response register ----------------
   ysyx_040066_rsp_buf u_rsp_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (buf_load),
      .load_data (bus.mem_rdata),
      .load_err  (bus.mem_rerr),
      .drop      (buf_drop),
      .valid     (buf_valid),
      .data      (buf_data),
      .err       (buf_err)
   );

   // ---------------- response routing ----------------
   assign i_rvalid     = buf_valid && own_fetch;
   assign d_rvalid     = buf_valid && !own_fetch;
   assign bus.i_rvalid = i_rvalid;
   assign bus.d_rvalid = d_rvalid;
   assign bus.i_instr  = pc2_q ? buf_data[63:32] : buf_data[31:0];
   assign bus.d_rdata  = buf_data;
   assign bus.i_rerr   = i_rvalid && buf_err;
   assign bus.d_rerr   = d_rvalid && buf_err;

endmodule
